id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of register/immediate/PC fields.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: if_id_rs1, if_id_rs2, if_id_rd  in  5  decoded register indices; if_id_uses_rs1, if_id_uses_rs2  in  1  operand actually read.
REQ-004 SHALL have ports: if_id_rdata1, if_id_rdata2, if_id_imm, if_id_pc  in  XLEN  decode-stage operands.
REQ-005 SHALL have ports: if_id_regwrite, if_id_memread, if_id_memwrite, if_id_memtoreg, if_id_branch, if_id_alusrc  in  1; if_id_aluop  in  2; if_id_alufn  in  4  control bundle.
REQ-006 SHALL have ports: if_id_valid  in  1  decode slot holds a real instruction; flush  in  1  taken branch/jump resolved downstream; hold  in  1  downstream back-pressure.
REQ-007 SHALL have ports: ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5; ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm, ID_EX_pc  out  XLEN; ID_EX_* control bundle out (same widths as REQ-005); ID_EX_valid  out  1.
REQ-008 SHALL have ports: pc_write, if_id_write  out  1  front-end advance enables; stall_cnt, flush_cnt  out  32  performance counters.

Function
REQ-009 Load-use hazard (lu) SHALL be asserted combinationally when ID_EX_valid && ID_EX_memread && ID_EX_rd!=0 && ((if_id_uses_rs1 && ID_EX_rd==if_id_rs1) || (if_id_uses_rs2 && ID_EX_rd==if_id_rs2)) && if_id_valid.
REQ-010 pc_write and if_id_write SHALL be 0 when (lu || hold) && !flush, else 1.
REQ-011 Register update priority per clock edge SHALL be rst > flush > hold > lu > load.
REQ-012 flush: ID_EX_valid<=0 and all ID_EX control bits<=0; data/index fields SHALL be don't-care but ID_EX_rd<=0.
REQ-013 hold (no flush): every ID_EX output SHALL retain its value.
REQ-014 lu (no flush, no hold): bubble inserted -- ID_EX_valid<=0, control bits<=0, ID_EX_rd<=0; front end frozen per REQ-010.
REQ-015 load (none of above): all ID_EX fields<=corresponding if_id_* inputs; ID_EX_valid<=if_id_valid; control bits forced 0 when if_id_valid=0.
REQ-016 Latency: one cycle from if_id_* to ID_EX_*; lu stall SHALL last exactly one cycle for a single dependent instruction.
REQ-017 ID_EX_regwrite SHALL never be 1 while ID_EX_valid=0.
REQ-018 stall_cnt SHALL increment by 1 on every edge where lu && !flush && !hold; flush_cnt on every edge where flush; both saturate at 32'hFFFF_FFFF.
REQ-019 Simultaneous flush and lu: flush wins, counts only in flush_cnt, front end not frozen.

Reset
REQ-020 On rst high at a clock edge all ID_EX outputs, ID_EX_valid, stall_cnt and flush_cnt SHALL become 0; rst mid-stall SHALL abort the stall the following cycle.
REQ-021 pc_write/if_id_write SHALL be 1 during reset (ID_EX_valid=0 implies no lu).

Structure
REQ-022 Control-bundle field widths and aluop encodings SHALL live in the shared pipeline package used by all stage registers.
REQ-023 lu detection SHALL be a sub-module hazard_detect (combinational); counters and register bank in id_ex_stage.

Verification
REQ-024 lw x5 in ID_EX (memread=1, rd=5), IF_ID add uses rs1=5 -> pc_write=0, if_id_write=0 one cycle, next ID_EX_valid=0, then add loads; stall_cnt=1.
REQ-025 Same as REQ-024 but rd=0 or if_id_uses_rs2=0 with rs2=5 only -> no stall, stall_cnt=0.
REQ-026 flush=1 together with lu condition -> ID_EX_valid=0, controls 0, pc_write=1, flush_cnt=1, stall_cnt=0.
REQ-027 hold=1 for 3 cycles with valid instruction latched -> ID_EX outputs constant, pc_write=0, counters unchanged.
REQ-028 rst asserted in the cycle lu is active -> next edge all outputs 0, pc_write=1, counters 0.
REQ-029 Preload stall_cnt to 32'hFFFF_FFFE via repeated lu (or force) then 3 lu cycles -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALU op encodings and
// the saturating counter helper used by the stage registers.
package id_ex_stage_pkg;

    localparam int REG_IDX_W = 5;
    localparam int ALUOP_W   = 2;
    localparam int ALUFN_W   = 4;
    localparam int CNT_W     = 32;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef struct packed {
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               branch;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic [ALUFN_W-1:0] alufn;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: the instruction in decode needs a register that the
// load currently in execute has not produced yet.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (ex_rd == id_rs1);
    assign rs2_hit = id_uses_rs2 && (ex_rd == id_rs2);

    // x0 is never a real destination, so a load into it cannot create a hazard.
    assign lu = ex_valid && ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit) && id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// hold and saturating stall/flush performance counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      if_id_rs1,
    input  logic [4:0]      if_id_rs2,
    input  logic [4:0]      if_id_rd,
    input  logic            if_id_uses_rs1,
    input  logic            if_id_uses_rs2,
    input  logic [XLEN-1:0] if_id_rdata1,
    input  logic [XLEN-1:0] if_id_rdata2,
    input  logic [XLEN-1:0] if_id_imm,
    input  logic [XLEN-1:0] if_id_pc,
    input  logic            if_id_regwrite,
    input  logic            if_id_memread,
    input  logic            if_id_memwrite,
    input  logic            if_id_memtoreg,
    input  logic            if_id_branch,
    input  logic            if_id_alusrc,
    input  logic [1:0]      if_id_aluop,
    input  logic [3:0]      if_id_alufn,
    input  logic            if_id_valid,
    input  logic            flush,
    input  logic            hold,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [XLEN-1:0] ID_EX_rdata1,
    output logic [XLEN-1:0] ID_EX_rdata2,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic [XLEN-1:0] ID_EX_pc,
    output logic            ID_EX_regwrite,
    output logic            ID_EX_memread,
    output logic            ID_EX_memwrite,
    output logic            ID_EX_memtoreg,
    output logic            ID_EX_branch,
    output logic            ID_EX_alusrc,
    output logic [1:0]      ID_EX_aluop,
    output logic [3:0]      ID_EX_alufn,
    output logic            ID_EX_valid,
    output logic            pc_write,
    output logic            if_id_write,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    logic                 valid_q, valid_d;
    ctrl_t                ctrl_q, ctrl_d;
    ctrl_t                in_ctrl;
    logic [REG_IDX_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]      rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic [XLEN-1:0]      imm_q, imm_d, pc_q, pc_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                 lu;

    assign in_ctrl = '{regwrite: if_id_regwrite, memread: if_id_memread,
                       memwrite: if_id_memwrite, memtoreg: if_id_memtoreg,
                       branch: if_id_branch, alusrc: if_id_alusrc,
                       aluop: if_id_aluop, alufn: if_id_alufn};

    hazard_detect u_hazard_detect (
        .ex_valid    (valid_q),
        .ex_memread  (ctrl_q.memread),
        .ex_rd       (rd_q),
        .id_valid    (if_id_valid),
        .id_uses_rs1 (if_id_uses_rs1),
        .id_uses_rs2 (if_id_uses_rs2),
        .id_rs1      (if_id_rs1),
        .id_rs2      (if_id_rs2),
        .lu          (lu)
    );

    // Flow control: flush kills the slot and always lets the front end
    // advance; hold freezes this register and the front end; a load-use
    // hazard inserts a bubble here while the front end re-presents the same
    // instruction next cycle. Reset keeps the front end enabled.
    assign pc_write    = rst || flush || !(lu || hold);
    assign if_id_write = pc_write;

    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            valid_d     = 1'b0;
            ctrl_d      = CTRL_NOP;
            rd_d        = '0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (hold) begin
            valid_d = valid_q;
        end else if (lu) begin
            valid_d     = 1'b0;
            ctrl_d      = CTRL_NOP;
            rd_d        = '0;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            valid_d  = if_id_valid;
            ctrl_d   = if_id_valid ? in_ctrl : CTRL_NOP;
            rs1_d    = if_id_rs1;
            rs2_d    = if_id_rs2;
            rd_d     = if_id_rd;
            rdata1_d = if_id_rdata1;
            rdata2_d = if_id_rdata2;
            imm_d    = if_id_imm;
            pc_d     = if_id_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ID_EX_valid    = valid_q;
    assign ID_EX_regwrite = ctrl_q.regwrite;
    assign ID_EX_memread  = ctrl_q.memread;
    assign ID_EX_memwrite = ctrl_q.memwrite;
    assign ID_EX_memtoreg = ctrl_q.memtoreg;
    assign ID_EX_branch   = ctrl_q.branch;
    assign ID_EX_alusrc   = ctrl_q.alusrc;
    assign ID_EX_aluop    = ctrl_q.aluop;
    assign ID_EX_alufn    = ctrl_q.alufn;
    assign ID_EX_rs1      = rs1_q;
    assign ID_EX_rs2      = rs2_q;
    assign ID_EX_rd       = rd_q;
    assign ID_EX_rdata1   = rdata1_q;
    assign ID_EX_rdata2   = rdata2_q;
    assign ID_EX_imm      = imm_q;
    assign ID_EX_pc       = pc_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: each vector pushes its expected front-end
// enable and post-edge register state; a monitor pops and compares per cycle.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [11:0] ctrl;
    } instr_t;

    typedef struct packed {
        logic        pcw;
        logic        chk_data;
        logic        valid;
        logic [11:0] ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] stall;
        logic [31:0] flush_c;
    } exp_t;

    // clock / reset and DUT signals
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  if_id_rs1, if_id_rs2, if_id_rd;
    logic        if_id_uses_rs1, if_id_uses_rs2;
    logic [31:0] if_id_rdata1, if_id_rdata2, if_id_imm, if_id_pc;
    logic        if_id_regwrite, if_id_memread, if_id_memwrite, if_id_memtoreg;
    logic        if_id_branch, if_id_alusrc;
    logic [1:0]  if_id_aluop;
    logic [3:0]  if_id_alufn;
    logic        if_id_valid, flush, hold;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [31:0] ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm, ID_EX_pc;
    logic        ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg;
    logic        ID_EX_branch, ID_EX_alusrc;
    logic [1:0]  ID_EX_aluop;
    logic [3:0]  ID_EX_alufn;
    logic        ID_EX_valid, pc_write, if_id_write;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
        .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
        .if_id_rdata1(if_id_rdata1), .if_id_rdata2(if_id_rdata2),
        .if_id_imm(if_id_imm), .if_id_pc(if_id_pc),
        .if_id_regwrite(if_id_regwrite), .if_id_memread(if_id_memread),
        .if_id_memwrite(if_id_memwrite), .if_id_memtoreg(if_id_memtoreg),
        .if_id_branch(if_id_branch), .if_id_alusrc(if_id_alusrc),
        .if_id_aluop(if_id_aluop), .if_id_alufn(if_id_alufn),
        .if_id_valid(if_id_valid), .flush(flush), .hold(hold),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2),
        .ID_EX_imm(ID_EX_imm), .ID_EX_pc(ID_EX_pc),
        .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
        .ID_EX_memwrite(ID_EX_memwrite), .ID_EX_memtoreg(ID_EX_memtoreg),
        .ID_EX_branch(ID_EX_branch), .ID_EX_alusrc(ID_EX_alusrc),
        .ID_EX_aluop(ID_EX_aluop), .ID_EX_alufn(ID_EX_alufn),
        .ID_EX_valid(ID_EX_valid), .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // scoreboard state
    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic u1, input logic u2,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  input logic [11:0] ctrl);
        instr_t i;
        i.valid = v;  i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.u1 = u1; i.u2 = u2;
        i.rdata1 = d1; i.rdata2 = d2; i.imm = imm; i.pc = pc; i.ctrl = ctrl;
        return i;
    endfunction

    function automatic exp_t e_load(input instr_t i, input logic pcw,
                                    input logic [31:0] s, input logic [31:0] f);
        exp_t e;
        e.pcw = pcw; e.chk_data = 1'b1; e.valid = i.valid;
        e.ctrl = i.valid ? i.ctrl : 12'h000;
        e.rd = i.rd; e.rs1 = i.rs1; e.rs2 = i.rs2;
        e.rdata1 = i.rdata1; e.rdata2 = i.rdata2; e.imm = i.imm; e.pc = i.pc;
        e.stall = s; e.flush_c = f;
        return e;
    endfunction

    function automatic exp_t e_bub(input logic pcw, input logic [31:0] s, input logic [31:0] f);
        exp_t e;
        e = '0;
        e.pcw = pcw; e.stall = s; e.flush_c = f;
        return e;
    endfunction

    function automatic exp_t e_rst();
        exp_t e;
        e = '0;
        e.pcw = 1'b1; e.chk_data = 1'b1;
        return e;
    endfunction

    // driver
    task automatic step(input instr_t i, input logic f, input logic h, input logic r, input exp_t e);
        @(negedge clk);
        rst = r; flush = f; hold = h;
        if_id_valid = i.valid; if_id_rs1 = i.rs1; if_id_rs2 = i.rs2; if_id_rd = i.rd;
        if_id_uses_rs1 = i.u1; if_id_uses_rs2 = i.u2;
        if_id_rdata1 = i.rdata1; if_id_rdata2 = i.rdata2; if_id_imm = i.imm; if_id_pc = i.pc;
        {if_id_regwrite, if_id_memread, if_id_memwrite, if_id_memtoreg,
         if_id_branch, if_id_alusrc, if_id_aluop, if_id_alufn} = i.ctrl;
        exp_q.push_back(e);
    endtask

    // monitor: front-end enables just before the edge, register state just after
    logic pcw_s, ifw_s;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            pcw_s = pc_write;
            ifw_s = if_id_write;
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                step_no++;
                chk("pc_write", {31'b0, pcw_s}, {31'b0, e.pcw});
                chk("if_id_write", {31'b0, ifw_s}, {31'b0, e.pcw});
                chk("valid", {31'b0, ID_EX_valid}, {31'b0, e.valid});
                chk("ctrl", {20'b0, ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg,
                             ID_EX_branch, ID_EX_alusrc, ID_EX_aluop, ID_EX_alufn},
                    {20'b0, e.ctrl});
                chk("rd", {27'b0, ID_EX_rd}, {27'b0, e.rd});
                chk("stall_cnt", stall_cnt, e.stall);
                chk("flush_cnt", flush_cnt, e.flush_c);
                chk("regwrite_without_valid", {31'b0, ID_EX_regwrite & ~ID_EX_valid}, 32'd0);
                if (e.chk_data) begin
                    chk("rs1", {27'b0, ID_EX_rs1}, {27'b0, e.rs1});
                    chk("rs2", {27'b0, ID_EX_rs2}, {27'b0, e.rs2});
                    chk("rdata1", ID_EX_rdata1, e.rdata1);
                    chk("rdata2", ID_EX_rdata2, e.rdata2);
                    chk("imm", ID_EX_imm, e.imm);
                    chk("pc", ID_EX_pc, e.pc);
                end
            end
        end
    end

    instr_t nop, lw, lw0, add, add2, add3, ghost;

    initial begin
        // ctrl = {regwrite,memread,memwrite,memtoreg,branch,alusrc,aluop[1:0],alufn[3:0]}
        nop   = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 12'h000);
        lw    = mk(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h100, 32'h0, 32'h8, 32'h40, 12'hD40);
        lw0   = mk(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 32'h104, 32'h0, 32'hC, 32'h50, 12'hD40);
        add   = mk(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, 32'h44, 12'h820);
        add2  = mk(1'b1, 5'd6, 5'd5, 5'd8, 1'b1, 1'b0, 32'h33, 32'h44, 32'h7, 32'h48, 12'h820);
        add3  = mk(1'b1, 5'd1, 5'd5, 5'd9, 1'b1, 1'b1, 32'h55, 32'h66, 32'h0, 32'h4C, 12'h820);
        ghost = mk(1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 12'hD40);

        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        {if_id_valid, if_id_rs1, if_id_rs2, if_id_rd, if_id_uses_rs1, if_id_uses_rs2} = '0;
        {if_id_rdata1, if_id_rdata2, if_id_imm, if_id_pc} = '0;
        {if_id_regwrite, if_id_memread, if_id_memwrite, if_id_memtoreg,
         if_id_branch, if_id_alusrc, if_id_aluop, if_id_alufn} = '0;

        // reset state
        step(nop, 1'b0, 1'b0, 1'b1, e_rst());
        step(nop, 1'b0, 1'b0, 1'b1, e_rst());
        // load-use on rs1: one bubble, then the add loads
        step(lw,   1'b0, 1'b0, 1'b0, e_load(lw, 1'b1, 0, 0));
        step(add,  1'b0, 1'b0, 1'b0, e_bub(1'b0, 1, 0));
        step(add,  1'b0, 1'b0, 1'b0, e_load(add, 1'b1, 1, 0));
        // load into x0 never stalls
        step(lw0,  1'b0, 1'b0, 1'b0, e_load(lw0, 1'b1, 1, 0));
        step(add,  1'b0, 1'b0, 1'b0, e_load(add, 1'b1, 1, 0));
        // rs2 matches but is not read
        step(lw,   1'b0, 1'b0, 1'b0, e_load(lw, 1'b1, 1, 0));
        step(add2, 1'b0, 1'b0, 1'b0, e_load(add2, 1'b1, 1, 0));
        // load-use on rs2
        step(lw,   1'b0, 1'b0, 1'b0, e_load(lw, 1'b1, 1, 0));
        step(add3, 1'b0, 1'b0, 1'b0, e_bub(1'b0, 2, 0));
        step(add3, 1'b0, 1'b0, 1'b0, e_load(add3, 1'b1, 2, 0));
        // flush together with a load-use hazard
        step(lw,   1'b0, 1'b0, 1'b0, e_load(lw, 1'b1, 2, 0));
        step(add,  1'b1, 1'b0, 1'b0, e_bub(1'b1, 2, 1));
        // hold for three cycles, outranking the hazard
        step(lw,   1'b0, 1'b0, 1'b0, e_load(lw, 1'b1, 2, 1));
        step(add,  1'b0, 1'b1, 1'b0, e_load(lw, 1'b0, 2, 1));
        step(add,  1'b0, 1'b1, 1'b0, e_load(lw, 1'b0, 2, 1));
        step(nop,  1'b0, 1'b1, 1'b0, e_load(lw, 1'b0, 2, 1));
        step(add,  1'b0, 1'b0, 1'b0, e_bub(1'b0, 3, 1));
        // invalid slot loads data but no control bits
        step(ghost, 1'b0, 1'b0, 1'b0, e_load(ghost, 1'b1, 3, 1));
        step(add,  1'b0, 1'b0, 1'b0, e_load(add, 1'b1, 3, 1));
        // reset while a hazard is active
        step(lw,   1'b0, 1'b0, 1'b0, e_load(lw, 1'b1, 3, 1));
        step(add,  1'b0, 1'b0, 1'b1, e_rst());
        step(add,  1'b0, 1'b0, 1'b0, e_load(add, 1'b1, 0, 0));

        // counter saturation: preload both counters just below the ceiling
        @(posedge clk);
        #2;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        force dut.flush_cnt_q = 32'hFFFF_FFFE;
        step(nop,  1'b0, 1'b0, 1'b0, e_load(nop, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE));
        @(posedge clk);
        #2;
        release dut.stall_cnt_q;
        release dut.flush_cnt_q;
        for (int k = 0; k < 3; k++) begin
            step(lw,  1'b0, 1'b0, 1'b0, e_load(lw, 1'b1, (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF,
                                               32'hFFFF_FFFE));
            step(add, 1'b0, 1'b0, 1'b0, e_bub(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
            step(add, 1'b0, 1'b0, 1'b0, e_load(add, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
        end
        step(nop,  1'b1, 1'b0, 1'b0, e_bub(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        step(nop,  1'b1, 1'b0, 1'b0, e_bub(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));

        repeat (3) @(posedge clk);
        #2;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
